// File: rtl/axi_wr_arbiter_if.sv
// Bus bundle for axi_wr_arbiter: the per-master AW/W inputs (packed, master i at
// slice i) and the single downstream AW/W channel.
//   slave  : arbiter view (takes s_* requests, drives the m_* channel)
//   master : environment view (drives s_* requests, sinks the m_* channel)
interface axi_wr_arbiter_if #(
   parameter int unsigned NUM_M  = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned ID_W   = 4,
   parameter int unsigned DATA_W = 32
);
   logic [NUM_M-1:0]        s_awvalid;
   logic [NUM_M-1:0]        s_awready;
   logic [NUM_M*ADDR_W-1:0] s_awaddr;
   logic [NUM_M*ID_W-1:0]   s_awid;
   logic [NUM_M*8-1:0]      s_awlen;

   logic                    m_awvalid;
   logic                    m_awready;
   logic [ADDR_W-1:0]       m_awaddr;
   logic [ID_W-1:0]         m_awid;
   logic [7:0]              m_awlen;

   logic [NUM_M-1:0]        s_wvalid;
   logic [NUM_M-1:0]        s_wlast;
   logic [NUM_M-1:0]        s_wready;
   logic [NUM_M*DATA_W-1:0] s_wdata;

   logic                    m_wvalid;
   logic                    m_wlast;
   logic                    m_wready;
   logic [DATA_W-1:0]       m_wdata;

   modport slave (
      input  s_awvalid, s_awaddr, s_awid, s_awlen,
      output s_awready,
      output m_awvalid, m_awaddr, m_awid, m_awlen,
      input  m_awready,
      input  s_wvalid, s_wlast, s_wdata,
      output s_wready,
      output m_wvalid, m_wlast, m_wdata,
      input  m_wready
   );

   modport master (
      output s_awvalid, s_awaddr, s_awid, s_awlen,
      input  s_awready,
      input  m_awvalid, m_awaddr, m_awid, m_awlen,
      output m_awready,
      output s_wvalid, s_wlast, s_wdata,
      input  s_wready,
      input  m_wvalid, m_wlast, m_wdata,
      output m_wready
   );
endinterface

// File: rtl/axi_wr_arbiter.sv
// AXI write-path arbiter: NUM_M masters share one slave-side AW + W path.
// AW requests are granted round-robin into a registered AW output stage; each
// granted master index is queued so W beats are steered, whole bursts at a
// time, in the same order the AWs were issued.
// Ports:
//   aclk, aresetn (async, active-low), srst (sync, active-high, same effect)
//   bus       : axi_wr_arbiter_if.slave (per-master AW/W in, downstream AW/W out)
//   ord_count : current write-order queue occupancy
module axi_wr_arbiter #(
   parameter int unsigned NUM_M    = 4,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned ID_W     = 4,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ORD_LOG2 = 2
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 srst,
   axi_wr_arbiter_if.slave      bus,
   output logic [ORD_LOG2:0]    ord_count
);

   localparam int unsigned IDX_W = $clog2(NUM_M);
   localparam int unsigned DEPTH = 2 ** ORD_LOG2;

   typedef logic [IDX_W-1:0] idx_t;

   // (base + off) mod NUM_M, valid for base, off < NUM_M.
   function automatic idx_t wrap_add(input idx_t base, input int off);
      logic [IDX_W:0] sum;
      sum = {1'b0, base} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_M)) begin
         sum = sum - (IDX_W+1)'(NUM_M);
      end
      return sum[IDX_W-1:0];
   endfunction

   // Per-master views of the packed request buses.
   logic [ADDR_W-1:0] aw_addr [NUM_M];
   logic [ID_W-1:0]   aw_id   [NUM_M];
   logic [7:0]        aw_len  [NUM_M];
   logic [DATA_W-1:0] w_data  [NUM_M];

   for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
      assign aw_addr[i] = bus.s_awaddr[i*ADDR_W +: ADDR_W];
      assign aw_id[i]   = bus.s_awid[i*ID_W +: ID_W];
      assign aw_len[i]  = bus.s_awlen[i*8 +: 8];
      assign w_data[i]  = bus.s_wdata[i*DATA_W +: DATA_W];
   end

   // State
   logic              aw_valid_q, aw_valid_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic [ID_W-1:0]   aw_id_q, aw_id_d;
   logic [7:0]        aw_len_q, aw_len_d;
   idx_t              rr_q, rr_d;
   idx_t              ord_q [DEPTH];
   logic [ORD_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [ORD_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [ORD_LOG2:0]   cnt_q, cnt_d;

   // Combinational
   logic             active;
   logic             slot_free;
   logic             full;
   logic             empty;
   logic             any_req;
   logic             grant;
   logic             push;
   logic             pop;
   idx_t             winner;
   idx_t             head;
   logic [NUM_M-1:0] awready;
   logic [NUM_M-1:0] wready;
   logic             wvalid;
   logic             wlast;
   logic [DATA_W-1:0] wdata;

   // Requests and W routing are suppressed while either reset is asserted.
   assign active    = aresetn & ~srst;
   assign slot_free = ~aw_valid_q | bus.m_awready;
   assign full      = (cnt_q == (ORD_LOG2+1)'(DEPTH));
   assign empty     = (cnt_q == '0);
   assign any_req   = |bus.s_awvalid;
   assign grant     = active & slot_free & ~full & any_req;
   assign push      = grant;
   assign head      = ord_q[rd_ptr_q];

   // Round-robin pick: scan downward so the lowest offset from rr wins.
   always_comb begin
      idx_t cand;
      winner = '0;
      for (int k = int'(NUM_M) - 1; k >= 0; k--) begin
         cand = wrap_add(rr_q, k);
         if (bus.s_awvalid[cand]) begin
            winner = cand;
         end
      end
   end

   always_comb begin
      awready = '0;
      if (grant) begin
         awready[winner] = 1'b1;
      end
   end

   always_comb begin
      aw_valid_d = aw_valid_q;
      aw_addr_d  = aw_addr_q;
      aw_id_d    = aw_id_q;
      aw_len_d   = aw_len_q;
      rr_d       = rr_q;
      if (grant) begin
         aw_valid_d = 1'b1;
         aw_addr_d  = aw_addr[winner];
         aw_id_d    = aw_id[winner];
         aw_len_d   = aw_len[winner];
         rr_d       = wrap_add(winner, 1);
      end else if (slot_free) begin
         aw_valid_d = 1'b0;
      end
   end

   // W steering from the queue head; the head stays put until its WLAST.
   always_comb begin
      wvalid = 1'b0;
      wlast  = 1'b0;
      wdata  = '0;
      wready = '0;
      if (active && !empty) begin
         wvalid       = bus.s_wvalid[head];
         wlast        = bus.s_wlast[head];
         wdata        = w_data[head];
         wready[head] = bus.m_wready;
      end
   end

   assign pop = wvalid & bus.m_wready & wlast;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         aw_valid_q <= 1'b0;
         aw_addr_q  <= '0;
         aw_id_q    <= '0;
         aw_len_q   <= '0;
         rr_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else if (srst) begin
         aw_valid_q <= 1'b0;
         aw_addr_q  <= '0;
         aw_id_q    <= '0;
         aw_len_q   <= '0;
         rr_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         aw_valid_q <= aw_valid_d;
         aw_addr_q  <= aw_addr_d;
         aw_id_q    <= aw_id_d;
         aw_len_q   <= aw_len_d;
         rr_q       <= rr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Queue storage needs no reset; occupancy alone defines valid entries.
   always_ff @(posedge aclk) begin
      if (push) begin
         ord_q[wr_ptr_q] <= winner;
      end
   end

   assign bus.s_awready = awready;
   assign bus.m_awvalid = aw_valid_q;
   assign bus.m_awaddr  = aw_addr_q;
   assign bus.m_awid    = aw_id_q;
   assign bus.m_awlen   = aw_len_q;
   assign bus.s_wready  = wready;
   assign bus.m_wvalid  = wvalid;
   assign bus.m_wlast   = wlast;
   assign bus.m_wdata   = wdata;
   assign ord_count     = cnt_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter (4 masters, 4-entry order queue).
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge (or 1 unit after an asynchronous input change).
module tb_axi_wr_arbiter;

   localparam int unsigned NUM_M    = 4;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned ID_W     = 4;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ORD_LOG2 = 2;

   logic             aclk;
   logic             aresetn;
   logic             srst;
   logic [ORD_LOG2:0] ord_count;

   int total = 0;
   int bad   = 0;

   int fair_exp [4] = '{1, 4, 1, 4};

   axi_wr_arbiter_if #(
      .NUM_M (NUM_M),
      .ADDR_W(ADDR_W),
      .ID_W  (ID_W),
      .DATA_W(DATA_W)
   ) bus ();

   axi_wr_arbiter #(
      .NUM_M   (NUM_M),
      .ADDR_W  (ADDR_W),
      .ID_W    (ID_W),
      .DATA_W  (DATA_W),
      .ORD_LOG2(ORD_LOG2)
   ) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .srst     (srst),
      .bus      (bus),
      .ord_count(ord_count)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic mid;
      @(negedge aclk);
   endtask

   task automatic set_aw(input int i, input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len);
      bus.s_awaddr[i*ADDR_W +: ADDR_W] = a;
      bus.s_awid[i*ID_W +: ID_W]       = id;
      bus.s_awlen[i*8 +: 8]            = len;
   endtask

   // Called on a falling edge with W inputs set up; accepts one beat from head h.
   task automatic drain(input int h);
      #1;
      chk("drain_wvalid", bus.m_wvalid, 1);
      chk("drain_wdata", bus.m_wdata, 32'hD0 + h);
      chk("drain_wready", bus.s_wready, 1 << h);
      tick;
      mid;
   endtask

   task automatic w_setup;
      bus.s_wvalid = 4'hF;
      bus.s_wlast  = 4'hF;
      bus.m_wready = 1'b1;
   endtask

   task automatic w_clear;
      bus.s_wvalid = 4'h0;
      bus.s_wlast  = 4'h0;
      bus.m_wready = 1'b0;
   endtask

   initial begin
      aresetn       = 1'b0;
      srst          = 1'b0;
      bus.s_awvalid = 4'hF;
      bus.m_awready = 1'b1;
      bus.s_wvalid  = '0;
      bus.s_wlast   = '0;
      bus.m_wready  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_aw(i, 32'h1000 * (i + 1), 4'(8 + i), 8'(i));
         bus.s_wdata[i*DATA_W +: DATA_W] = 32'hD0 + i;
      end

      // Reset state, with requests pending
      tick;
      tick;
      mid;
      chk("rst_awvalid", bus.m_awvalid, 0);
      chk("rst_awaddr", bus.m_awaddr, 0);
      chk("rst_count", ord_count, 0);
      chk("rst_awready", bus.s_awready, 0);
      chk("rst_wvalid", bus.m_wvalid, 0);

      // Back-to-back grants 0,1,2,3
      aresetn = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("bb_awready", bus.s_awready, 1 << k);
         tick;
         bus.s_awvalid[k] = 1'b0;
         mid;
         chk("bb_awvalid", bus.m_awvalid, 1);
         chk("bb_awid", bus.m_awid, 8 + k);
         chk("bb_count", ord_count, k + 1);
      end
      chk("bb_awaddr", bus.m_awaddr, 32'h4000);
      chk("bb_awlen", bus.m_awlen, 3);
      chk("bb_idle", bus.s_awready, 0);
      w_setup;
      drain(0);
      drain(1);
      drain(2);
      drain(3);
      chk("bb_empty", ord_count, 0);
      chk("bb_awdrop", bus.m_awvalid, 0);
      w_clear;

      // Fairness: masters 0 and 2 request continuously (rr = 0)
      bus.s_awvalid = 4'b0101;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("fair_awready", bus.s_awready, fair_exp[k]);
         tick;
         mid;
      end
      chk("fair_count", ord_count, 4);
      chk("fair_full", bus.s_awready, 0);
      bus.s_awvalid = 4'b0000;
      w_setup;
      drain(0);
      drain(2);
      drain(0);
      drain(2);
      w_clear;

      // Downstream stall (rr = 3): master 1 granted, master 3 waits
      bus.m_awready = 1'b0;
      bus.s_awvalid = 4'b0010;
      #1;
      chk("stall_grant", bus.s_awready, 4'b0010);
      tick;
      bus.s_awvalid = 4'b1000;
      mid;
      for (int k = 0; k < 5; k++) begin
         chk("stall_awready", bus.s_awready, 0);
         chk("stall_awvalid", bus.m_awvalid, 1);
         chk("stall_awaddr", bus.m_awaddr, 32'h2000);
         chk("stall_awid", bus.m_awid, 9);
         chk("stall_awlen", bus.m_awlen, 1);
         tick;
         mid;
      end
      bus.m_awready = 1'b1;
      #1;
      chk("stall_release", bus.s_awready, 4'b1000);
      tick;
      bus.s_awvalid = 4'b0000;
      mid;
      chk("stall_awid3", bus.m_awid, 11);
      chk("stall_count", ord_count, 2);
      w_setup;
      drain(1);
      drain(3);
      chk("stall_awdrop", bus.m_awvalid, 0);
      w_clear;

      // Queue full (rr = 0): 4 grants, master 0 keeps requesting
      bus.s_awvalid = 4'hF;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("qf_awready", bus.s_awready, 1 << k);
         tick;
         if (k != 0) bus.s_awvalid[k] = 1'b0;
         mid;
      end
      chk("qf_count", ord_count, 4);
      chk("qf_block", bus.s_awready, 0);
      tick;
      mid;
      chk("qf_block2", bus.s_awready, 0);
      bus.m_wready = 1'b1;
      bus.s_wvalid = 4'b0001;
      bus.s_wlast  = 4'b0001;
      #1;
      chk("qf_wvalid", bus.m_wvalid, 1);
      chk("qf_popcycle", bus.s_awready, 0);
      tick;
      bus.s_wvalid = 4'b0000;
      mid;
      chk("qf_count3", ord_count, 3);
      chk("qf_regrant", bus.s_awready, 4'b0001);
      tick;
      bus.s_awvalid = 4'b0000;
      mid;
      chk("qf_count4", ord_count, 4);
      chk("qf_awid", bus.m_awid, 8);
      w_setup;
      drain(1);
      drain(2);
      drain(3);
      drain(0);
      w_clear;

      // W ordering (rr = 1): master 1 (len 3) then master 0 (len 0)
      set_aw(1, 32'h2000, 4'd9, 8'd3);
      bus.s_wvalid  = 4'b0001;
      bus.s_wlast   = 4'b0001;
      bus.m_wready  = 1'b1;
      bus.s_awvalid = 4'b0011;
      #1;
      chk("wo_early_wready", bus.s_wready, 0);
      chk("wo_early_wvalid", bus.m_wvalid, 0);
      chk("wo_grant1", bus.s_awready, 4'b0010);
      tick;
      bus.s_awvalid = 4'b0001;
      mid;
      chk("wo_head1_wready", bus.s_wready, 4'b0010);
      chk("wo_head1_wvalid", bus.m_wvalid, 0);
      chk("wo_grant0", bus.s_awready, 4'b0001);
      tick;
      bus.s_awvalid = 4'b0000;
      bus.s_wvalid  = 4'b0011;
      for (int b = 0; b < 4; b++) begin
         bus.s_wdata[1*DATA_W +: DATA_W] = 32'hE0 + b;
         bus.s_wlast[1] = (b == 3);
         mid;
         chk("wo_wdata", bus.m_wdata, 32'hE0 + b);
         chk("wo_wlast", bus.m_wlast, (b == 3) ? 1 : 0);
         chk("wo_wready", bus.s_wready, 4'b0010);
         tick;
      end
      bus.s_wvalid = 4'b0001;
      bus.s_wdata[1*DATA_W +: DATA_W] = 32'hD1;
      mid;
      chk("wo_m0_wdata", bus.m_wdata, 32'hD0);
      chk("wo_m0_wready", bus.s_wready, 4'b0001);
      chk("wo_m0_wlast", bus.m_wlast, 1);
      chk("wo_m0_count", ord_count, 1);
      tick;
      mid;
      chk("wo_empty", ord_count, 0);
      w_clear;

      // Reset mid-burst (rr = 1): master 2, len 3, AW held by m_awready=0
      set_aw(2, 32'h3000, 4'd10, 8'd3);
      bus.m_awready = 1'b0;
      bus.s_awvalid = 4'b0100;
      #1;
      chk("mr_grant", bus.s_awready, 4'b0100);
      tick;
      bus.s_awvalid = 4'b0000;
      bus.s_wvalid  = 4'b0100;
      bus.m_wready  = 1'b1;
      mid;
      chk("mr_beat1", bus.m_wvalid, 1);
      tick;
      #2;
      chk("mr_beat2", bus.m_wvalid, 1);
      aresetn       = 1'b0;
      bus.s_awvalid = 4'b1001;
      #1;
      chk("mr_awvalid", bus.m_awvalid, 0);
      chk("mr_wvalid", bus.m_wvalid, 0);
      chk("mr_count", ord_count, 0);
      chk("mr_awready", bus.s_awready, 0);
      chk("mr_wready", bus.s_wready, 0);
      mid;
      aresetn       = 1'b1;
      bus.m_awready = 1'b1;
      bus.s_wvalid  = 4'b0000;
      bus.m_wready  = 1'b0;
      #1;
      chk("mr_first_grant", bus.s_awready, 4'b0001);
      tick;
      bus.s_awvalid = 4'b0000;
      mid;
      chk("mr_count1", ord_count, 1);

      // Synchronous reset clears the same state
      srst          = 1'b1;
      bus.s_awvalid = 4'b0010;
      #1;
      chk("sr_awready", bus.s_awready, 0);
      tick;
      mid;
      chk("sr_count", ord_count, 0);
      chk("sr_awvalid", bus.m_awvalid, 0);
      chk("sr_awaddr", bus.m_awaddr, 0);
      srst = 1'b0;
      #1;
      chk("sr_grant", bus.s_awready, 4'b0010);
      tick;
      bus.s_awvalid = 4'b0000;
      mid;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

- Shares one AXI slave-side write path (AW + W) between NUM_M masters.
- AW requests are granted round-robin into a single registered AW output stage.
- The granted master index is pushed into an internal write-order queue; the queue head steers W beats from that master until WLAST.
- Sits in the crossbar in front of each slave port; B routing is handled by a separate block.

## Interface
- NUM_M, 4: number of masters (2..8).
- ADDR_W, 32: AW address width.
- ID_W, 4: AWID width.
- DATA_W, 32: W data width.
- ORD_LOG2, 2: log2 of order-queue depth (depth = 2**ORD_LOG2).
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- srst  in  1  synchronous reset, active-high, same effect as aresetn.
- s_awvalid / s_awready  in / out  NUM_M  per-master AW handshake.
- s_awaddr  in  NUM_M*ADDR_W  packed; master i at [i*ADDR_W +: ADDR_W].
- s_awid  in  NUM_M*ID_W  packed.
- s_awlen  in  NUM_M*8  packed.
- m_awvalid, m_awready  out, in  1  downstream AW handshake.
- m_awaddr, m_awid, m_awlen  out  ADDR_W, ID_W, 8  registered AW payload.
- s_wvalid, s_wlast / s_wready  in / out  NUM_M  per-master W handshake.
- s_wdata  in  NUM_M*DATA_W  packed.
- m_wvalid, m_wlast, m_wdata  out  1, 1, DATA_W  downstream W.
- m_wready  in  1.
- ord_count  out  ORD_LOG2+1  current order-queue occupancy.

## Operation
- **Reset (aresetn low or srst high):**
  - m_awvalid=0; m_awaddr/id/len=0.
  - Round-robin pointer rr=0; order queue empty; ord_count=0.
  - All s_awready=0, s_wready=0, m_wvalid=0.
- **AW slot free** when !m_awvalid || m_awready.
- **Grant condition:** slot free AND queue not full (full = occupancy 2**ORD_LOG2) AND any s_awvalid.
- **Winner:** first i with s_awvalid[i], scanning rr, rr+1, ... modulo NUM_M.
- **On grant, in the same cycle:**
  - s_awready[winner]=1, all others 0 (combinational).
  - Winner's payload loads into the m_aw register; m_awvalid=1 next cycle.
  - Winner index is pushed into the queue.
  - rr updates to (winner+1) mod NUM_M.
- **Slot free, no grant:**
  - If m_awready was the reason the slot freed, m_awvalid drops to 0.
  - rr is unchanged.
- **Payload stability:** m_aw payload holds stable while m_awvalid && !m_awready.
- **W routing:**
  - Queue non-empty with head h: m_wvalid=s_wvalid[h], m_wdata=s_wdata[h], m_wlast=s_wlast[h], s_wready[h]=m_wready. All other s_wready=0.
  - Queue empty: m_wvalid=0, m_wlast=0, m_wdata=0, all s_wready=0.
- **Pop:** on m_wvalid && m_wready && m_wlast.
- **No interleaving:** one master's full burst is completed before the next head.
- **Simultaneous push and pop:** both take effect; occupancy unchanged.
- **Queue full:**
  - Push is blocked by current-cycle fullness, even if a pop occurs in that cycle.
  - AW arbitration stalls; W draining continues.
- **W before AW:** W from a master with no queued entry stalls (s_wready=0) until its AW is granted and reaches the head.
- **Reset mid-operation:**
  - Queue and AW register are cleared immediately.
  - In-flight bursts are dropped; recovery is the system's responsibility.

## Timing
- AW latency: 1 cycle from s_awvalid&&s_awready to m_awvalid.
- AW throughput: 1 grant per cycle while m_awready=1 and the queue is not full.
- W path is combinational; no added latency or register.
- Earliest W routing: the cycle after the AW grant (queue push is registered).
- ord_count updates the cycle after push/pop.
- The W-side pop frees a queue entry for arbitration in the next cycle.

## Test plan
- **Back-to-back grants:** all 4 masters assert awvalid with m_awready=1 after reset → grants in order 0,1,2,3 on consecutive cycles; m_awid sequence matches; ord_count reaches 4.
- **Fairness:** master 2 asserts awvalid continuously alongside master 0 → grants alternate 0,2,0,2; neither is granted twice in a row.
- **Downstream stall:** m_awready=0 for 5 cycles → m_awaddr/id/len stable; no s_awready asserted; on release the next grant is taken in the same cycle.
- **Queue full:** ORD_LOG2=2, m_wready=0, 5 AW requests → 4 granted, 5th stalls. One WLAST beat accepted → 5th granted the following cycle.
- **W ordering:** AWs granted to masters 1 (len 3) then 0 (len 0); master 0 presents W first → master 0 stalls until 4 beats of master 1 complete with m_wlast on the 4th; then master 0's single beat passes.
- **Reset mid-burst:** aresetn pulsed low during beat 2 of 4 → m_awvalid=0, m_wvalid=0, ord_count=0 immediately; post-reset first grant goes to master 0.
